wmem_stream: RTL and testbench

WMEM_STREAM -- requirements
Module: wmem_stream

---
 rtl/wmem_stream.sv | 192 +++++++++++++++++++
 tb/tb_wmem_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wmem_stream.sv
// Layered weight memory with a post-reset clear sweep and a row streamer feeding a 2-entry output buffer.
// Define WMEM_STREAM_FWD_EN to forward a committing write into a same-address read.
module wmem_stream #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 8,
    parameter int N_OUT    = 4,
    parameter int N_LAYERS = 2,
    localparam int DEPTH = N_LAYERS * N_OUT * N_IN,
    localparam int LW    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
    localparam int HW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_wr_en,
    input  logic [LW-1:0]            w_layer,
    input  logic [HW-1:0]            w_addr_h,
    input  logic [IW-1:0]            w_addr_i,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     row_req,
    input  logic [LW-1:0]            row_layer,
    input  logic [HW-1:0]            row_h,
    output logic                     row_busy,
    output logic                     init_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IW-1:0]            out_idx,
    output logic                     out_last,
    output logic [1:0]               fsm_state
);

    typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1, S_STREAM = 2'd2} state_t;

    state_t                   state;
    logic [AW-1:0]            clr_addr;
    logic [LW-1:0]            lay_q;
    logic [HW-1:0]            row_q;
    logic [IW:0]              rd_cnt;
    logic                     rd_vld;
    logic [IW-1:0]            rd_idx;
    logic                     rd_last;
    logic signed [DATA_W-1:0] rd_q;
    logic                     tl_vld;
    logic signed [DATA_W-1:0] tl_data;
    logic [IW-1:0]            tl_idx;
    logic                     tl_last;
    logic                     wp_vld;
    logic [AW-1:0]            wp_addr;
    logic signed [DATA_W-1:0] wp_data;
    logic signed [DATA_W-1:0] mem [DEPTH];

    logic                     w_ok;
    logic                     req_ok;
    logic                     pop;
    logic                     rd_en;
    logic                     mem_we;
    logic [1:0]               occ;
    logic [AW-1:0]            w_flat;
    logic [AW-1:0]            rd_addr;
    logic [AW-1:0]            mem_waddr;
    logic signed [DATA_W-1:0] mem_wdata;

    // Output handshake: a word moves on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_idx/out_last are held.
    always_comb begin
        w_ok = w_wr_en && (state != S_CLEAR) && (32'(w_layer) < N_LAYERS) &&
               (32'(w_addr_h) < N_OUT) && (32'(w_addr_i) < N_IN);
        req_ok = (32'(row_layer) < N_LAYERS) && (32'(row_h) < N_OUT);
        w_flat = AW'(32'(w_layer) * N_OUT * N_IN + 32'(w_addr_h) * N_IN + 32'(w_addr_i));
        rd_addr = AW'(32'(lay_q) * N_OUT * N_IN + 32'(row_q) * N_IN + 32'(rd_cnt));
        pop = out_valid && out_ready;
        occ = 2'(out_valid) + 2'(tl_vld) + 2'(rd_vld);
        // A word leaving this cycle frees its slot for a read issued in the same cycle.
        rd_en = (state == S_STREAM) && (32'(rd_cnt) < N_IN) && ((occ - 2'(pop)) < 2'd2);
        mem_we = (state == S_CLEAR) || wp_vld;
        mem_waddr = (state == S_CLEAR) ? clr_addr : wp_addr;
        mem_wdata = (state == S_CLEAR) ? '0 : wp_data;
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
`ifdef WMEM_STREAM_FWD_EN
        if (rd_en) rd_q <= (mem_we && (mem_waddr == rd_addr)) ? mem_wdata : mem[rd_addr];
`else
        if (rd_en) rd_q <= mem[rd_addr];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            clr_addr  <= '0;
            init_done <= 1'b0;
            row_busy  <= 1'b1;
            lay_q     <= '0;
            row_q     <= '0;
            rd_cnt    <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            rd_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            tl_vld    <= 1'b0;
            tl_data   <= '0;
            tl_idx    <= '0;
            tl_last   <= 1'b0;
            wp_vld    <= 1'b0;
            wp_addr   <= '0;
            wp_data   <= '0;
        end else begin
            wp_vld <= w_ok;
            if (w_ok) begin
                wp_addr <= w_flat;
                wp_data <= w_data;
            end

            rd_vld <= rd_en;
            if (rd_en) begin
                rd_idx  <= rd_cnt[IW-1:0];
                rd_last <= (32'(rd_cnt) == N_IN - 1);
                rd_cnt  <= rd_cnt + (IW+1)'(1);
            end

            // Head register drives the outputs; the tail only fills while the head is stuck.
            if (pop) begin
                if (tl_vld) begin
                    out_data <= tl_data;
                    out_idx  <= tl_idx;
                    out_last <= tl_last;
                    tl_vld   <= rd_vld;
                    if (rd_vld) begin
                        tl_data <= rd_q;
                        tl_idx  <= rd_idx;
                        tl_last <= rd_last;
                    end
                end else if (rd_vld) begin
                    out_data <= rd_q;
                    out_idx  <= rd_idx;
                    out_last <= rd_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_vld) begin
                if (out_valid) begin
                    tl_vld  <= 1'b1;
                    tl_data <= rd_q;
                    tl_idx  <= rd_idx;
                    tl_last <= rd_last;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= rd_q;
                    out_idx   <= rd_idx;
                    out_last  <= rd_last;
                end
            end

            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == AW'(DEPTH - 1)) begin
                        clr_addr  <= '0;
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                        row_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (row_req && req_ok) begin
                        lay_q    <= row_layer;
                        row_q    <= row_h;
                        rd_cnt   <= '0;
                        row_busy <= 1'b1;
                        state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pop && out_last) begin
                        state    <= S_IDLE;
                        row_busy <= 1'b0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_wmem_stream.sv
// Bench for wmem_stream: randomized writes/streams against an array model, scoreboard monitor,
// directed latency/stall/collision/reset-abort cases, and a small second instance for range drops.
module tb_wmem_stream;
    localparam int DATA_W   = 16;
    localparam int N_IN     = 8;
    localparam int N_OUT    = 4;
    localparam int N_LAYERS = 2;
    localparam int DEPTH    = N_LAYERS * N_OUT * N_IN;
    localparam int IW       = 3;
    localparam int W        = DATA_W + IW + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              w_wr_en = 1'b0;
    logic [0:0]        w_layer = '0;
    logic [1:0]        w_addr_h = '0;
    logic [2:0]        w_addr_i = '0;
    logic [15:0]       w_data = '0;
    logic              row_req = 1'b0;
    logic [0:0]        row_layer = '0;
    logic [1:0]        row_h = '0;
    logic              out_ready = 1'b1;
    logic              row_busy, init_done, out_valid, out_last;
    logic [15:0]       out_data;
    logic [2:0]        out_idx;
    logic [1:0]        fsm_state;

    wmem_stream #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .N_LAYERS(N_LAYERS)) dut (
        .clk(clk), .rst_n(rst_n), .w_wr_en(w_wr_en), .w_layer(w_layer), .w_addr_h(w_addr_h),
        .w_addr_i(w_addr_i), .w_data(w_data), .row_req(row_req), .row_layer(row_layer),
        .row_h(row_h), .row_busy(row_busy), .init_done(init_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .fsm_state(fsm_state)
    );

    // Non-power-of-two instance so out-of-range fields are actually representable.
    logic        s_w_wr_en = 1'b0;
    logic [1:0]  s_w_layer = '0;
    logic [1:0]  s_w_addr_h = '0;
    logic [2:0]  s_w_addr_i = '0;
    logic [15:0] s_w_data = '0;
    logic        s_row_req = 1'b0;
    logic [1:0]  s_row_layer = '0;
    logic [1:0]  s_row_h = '0;
    logic        s_out_ready = 1'b1;
    logic        s_row_busy, s_init_done, s_out_valid, s_out_last;
    logic [15:0] s_out_data;
    logic [2:0]  s_out_idx;
    logic [1:0]  s_fsm_state;

    wmem_stream #(.DATA_W(16), .N_IN(5), .N_OUT(3), .N_LAYERS(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .w_wr_en(s_w_wr_en), .w_layer(s_w_layer), .w_addr_h(s_w_addr_h),
        .w_addr_i(s_w_addr_i), .w_data(s_w_data), .row_req(s_row_req), .row_layer(s_row_layer),
        .row_h(s_row_h), .row_busy(s_row_busy), .init_done(s_init_done), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last),
        .fsm_state(s_fsm_state)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  model [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    logic         held_v = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] exp_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", {12'd0, out_last, out_idx, out_data}, {12'd0, held});
            end
            held_v = out_valid && !out_ready;
            held = {out_last, out_idx, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {12'd0, out_last, out_idx, out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("stream_word", {12'd0, out_last, out_idx, out_data}, {12'd0, exp_w});
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        w_wr_en = 1'b0;
        row_req = 1'b0;
        out_ready = 1'b1;
        s_w_wr_en = 1'b0;
        s_row_req = 1'b0;
        tick(2);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_row_busy", {31'd0, row_busy}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_idx", {29'd0, out_idx}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        foreach (model[i]) model[i] = '0;
        exp_q.delete();
        // Writes and a row request held through the sweep must both be ignored.
        w_wr_en = 1'b1; w_layer = '0; w_addr_h = '0; w_addr_i = '0; w_data = 16'h1234;
        row_layer = '0; row_h = '0; row_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        w_wr_en = 1'b0;
        row_req = 1'b0;
        check("init_latency", n, 64);
        check("busy_after_sweep", {31'd0, row_busy}, 32'd0);
        check("s_init_done", {31'd0, s_init_done}, 32'd1);
    endtask

    task automatic write_word(input int l, input int h, input int i, input logic [15:0] d);
        w_layer = 1'(l); w_addr_h = 2'(h); w_addr_i = 3'(i); w_data = d; w_wr_en = 1'b1;
        tick(1);
        w_wr_en = 1'b0;
        model[l * N_OUT * N_IN + h * N_IN + i] = d;
    endtask

    // mode: 0 ready high, 1 random ready, 2 stall at idx 3, 3 write collides with idx 4 read,
    // 4 reset asserted while idx 5 is presented
    task automatic stream_row(input int l, input int h, input int mode);
        int c;
        int base;
        base = l * N_OUT * N_IN + h * N_IN;
`ifdef WMEM_STREAM_FWD_EN
        if (mode == 3) model[base + 4] = 16'h7FFF;
`endif
        for (int i = 0; i < N_IN; i++) exp_q.push_back({(i == N_IN - 1), 3'(i), model[base + i]});
        if (mode == 3) model[base + 4] = 16'h7FFF;
        check("idle_before_req", {31'd0, row_busy}, 32'd0);
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        row_layer = 1'(l); row_h = 2'(h); row_req = 1'b1;
        tick(1);
        row_req = 1'b0;
        check("busy_after_accept", {31'd0, row_busy}, 32'd1);
        c = 0;
        while (row_busy && c < 300) begin
            @(negedge clk);
            if (mode != 1 && c < 3) check("first_valid_lat", {31'd0, out_valid}, {31'd0, c == 2});
            if (mode == 2 && c >= 5 && c < 10) check("stall_idx", {29'd0, out_idx}, 32'd3);
            @(posedge clk);
            #1;
            c++;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = !(c >= 5 && c < 10);
                3: begin
                    w_layer = 1'(l); w_addr_h = 2'(h); w_addr_i = 3'd4; w_data = 16'h7FFF;
                    w_wr_en = (c == 3);
                end
                4: if (c == 7) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_valid", {31'd0, out_valid}, 32'd0);
                    check("abort_busy", {31'd0, row_busy}, 32'd1);
                    exp_q.delete();
                    return;
                end
                default: ;
            endcase
        end
        out_ready = 1'b1;
        check("stream_done", {31'd0, row_busy}, 32'd0);
        if (mode == 0 || mode == 3) check("stream_cycles", c, N_IN + 2);
        if (mode == 2) check("stream_cycles", c, N_IN + 7);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic s_write(input int l, input int h, input int i, input logic [15:0] d);
        s_w_layer = 2'(l); s_w_addr_h = 2'(h); s_w_addr_i = 3'(i); s_w_data = d; s_w_wr_en = 1'b1;
        tick(1);
        s_w_wr_en = 1'b0;
    endtask

    task automatic s_stream(input int l, input int h, input logic [15:0] first);
        int got;
        s_row_layer = 2'(l); s_row_h = 2'(h); s_row_req = 1'b1;
        tick(1);
        s_row_req = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (s_out_valid) begin
                check("s_data", {16'd0, s_out_data}, (got == 0) ? {16'd0, first} : 32'd0);
                check("s_idx", {29'd0, s_out_idx}, got);
                check("s_last", {31'd0, s_out_last}, {31'd0, got == 4});
                got++;
            end
        end
        check("s_word_count", got, 5);
        tick(1);
        check("s_busy_done", {31'd0, s_row_busy}, 32'd0);
    endtask

    task automatic s_bad_req(input int l, input int h);
        s_row_layer = 2'(l); s_row_h = 2'(h); s_row_req = 1'b1;
        tick(1);
        s_row_req = 1'b0;
        check("s_bad_req_busy", {31'd0, s_row_busy}, 32'd0);
        tick(2);
        check("s_bad_req_busy_later", {31'd0, s_row_busy}, 32'd0);
        check("s_bad_req_valid", {31'd0, s_out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        stream_row(1, 2, 0);
        stream_row(0, 0, 1);

        for (int l = 0; l < N_LAYERS; l++)
            for (int h = 0; h < N_OUT; h++)
                for (int i = 0; i < N_IN; i++)
                    write_word(l, h, i, 16'(l * 100 + h * 10 + i + 1));
        stream_row(1, 2, 0);
        stream_row(0, 3, 2);
        stream_row(0, 1, 3);
        stream_row(0, 1, 0);

        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++)
                write_word($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7), 16'($urandom));
            stream_row($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
        end

        stream_row(1, 1, 4);
        do_reset();
        for (int l = 0; l < N_LAYERS; l++)
            for (int h = 0; h < N_OUT; h++)
                stream_row(l, h, 0);

        s_write(0, 1, 0, 16'h0111);
        s_write(1, 0, 0, 16'h0222);
        s_write(0, 0, 5, 16'h0BAD);
        s_write(0, 3, 0, 16'h0BAD);
        s_write(3, 0, 0, 16'h0BAD);
        s_bad_req(0, 3);
        s_bad_req(3, 0);
        s_stream(0, 1, 16'h0111);
        s_stream(1, 0, 16'h0222);
        s_stream(2, 2, 16'h0000);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
